// File: rtl/mux_2x1_rr_arbiter_seq.sv
// -----------------------------------------------------------------------------
// mux_2x1_rr_arbiter_seq
//   Arbitration controller for the 2-to-1 sequential mux in the NoC merge
//   stage. Two packet requesters (0 = low branch, 1 = high branch) share the
//   mux. Each grant covers a whole packet and ends only on a transfer that
//   carries i_last. Arbitration is either round-robin with a per-grant packet
//   quota or fixed priority (low wins).
//
// Ports
//   clk              clock; all state updates on the rising edge
//   rst_n            asynchronous active-low reset
//   i_req[1:0]       requester k holds a valid beat
//   i_last[1:0]      the current beat of requester k ends its packet
//   o_ack[1:0]       requester k is granted; a beat moves when i_req[k] & o_ack[k]
//   o_mux_en         mux enable; high while any requester is granted
//   o_mux_cmd        mux select; 0 = low branch, 1 = high branch
//   o_mux_valid[1:0] mux per-branch valid, i_req & o_ack
//   o_busy           high while a packet is granted
//   i_cfg_mode       0 = round-robin, 1 = fixed priority
//   i_cfg_burst_max  round-robin packets per grant before yielding (0 acts as 1)
// -----------------------------------------------------------------------------
module mux_2x1_rr_arbiter_seq #(
  parameter int COMMAND_WIDTH   = 1,
  parameter int BURST_CNT_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 i_req,
  input  logic [1:0]                 i_last,
  output logic [1:0]                 o_ack,
  output logic                       o_mux_en,
  output logic [COMMAND_WIDTH-1:0]   o_mux_cmd,
  output logic [1:0]                 o_mux_valid,
  output logic                       o_busy,
  input  logic                       i_cfg_mode,
  input  logic [BURST_CNT_WIDTH-1:0] i_cfg_burst_max
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GNT_LOW  = 2'd1,
    GNT_HIGH = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [BURST_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                       last_served_q, last_served_d;  // 0 = low, 1 = high
  logic [1:0]                 ack_q;

  // Side currently granted (only meaningful outside IDLE) and its opponent.
  logic cur_side;
  logic oth_side;
  logic end_of_pkt;

  logic [BURST_CNT_WIDTH-1:0] burst_eff;
  logic [BURST_CNT_WIDTH:0]   cnt_inc;
  logic                       quota_hit;
  logic [BURST_CNT_WIDTH-1:0] cnt_sat_inc;

  function automatic state_e grant_of(input logic side);
    return side ? GNT_HIGH : GNT_LOW;
  endfunction

  assign cur_side   = (state_q == GNT_HIGH);
  assign oth_side   = ~cur_side;
  // An i_last without a matching transfer does not end the packet.
  assign end_of_pkt = (state_q != IDLE) && i_req[cur_side] && i_last[cur_side];

  // A quota of zero would never let the current owner keep the grant, so it
  // is treated as one packet per grant.
  assign burst_eff   = (i_cfg_burst_max == '0) ? BURST_CNT_WIDTH'(1) : i_cfg_burst_max;
  // One extra bit so the packet that just ended can be compared without wrap.
  assign cnt_inc     = {1'b0, cnt_q} + (BURST_CNT_WIDTH+1)'(1);
  assign quota_hit   = (cnt_inc >= {1'b0, burst_eff});
  assign cnt_sat_inc = (&cnt_q) ? cnt_q : cnt_q + BURST_CNT_WIDTH'(1);

  always_comb begin
    // NOTE: every next-state signal takes its hold value first, so no path
    // through the case below can leave one unassigned and infer a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    last_served_d = last_served_q;

    unique case (state_q)
      IDLE: begin
        if (i_req == 2'b11) begin
          // Round-robin from IDLE favours whoever was not served last.
          state_d = i_cfg_mode ? GNT_LOW : grant_of(~last_served_q);
        end else if (i_req[0]) begin
          state_d = GNT_LOW;
        end else if (i_req[1]) begin
          state_d = GNT_HIGH;
        end
      end

      GNT_LOW, GNT_HIGH: begin
        // Mid-packet (including stalls) the grant is held unchanged.
        if (end_of_pkt) begin
          if (i_cfg_mode) begin
            cnt_d         = '0;
            last_served_d = cur_side;
            if      (i_req[0]) state_d = GNT_LOW;
            else if (i_req[1]) state_d = GNT_HIGH;
            else               state_d = IDLE;
          end else if (i_req[oth_side] && quota_hit) begin
            state_d       = grant_of(oth_side);
            cnt_d         = '0;
            last_served_d = cur_side;
          end else if (!quota_hit && i_req[cur_side]) begin
            cnt_d = cnt_sat_inc;
          end else begin
            state_d       = i_req[oth_side] ? grant_of(oth_side) : IDLE;
            cnt_d         = '0;
            last_served_d = cur_side;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      last_served_q <= 1'b1;  // low is preferred on the first contention
      ack_q         <= 2'b00;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_served_q <= last_served_d;
      // Grant bits are registered alongside the state they decode, so o_ack
      // has no combinational path from i_req.
      ack_q         <= {state_d == GNT_HIGH, state_d == GNT_LOW};
    end
  end

  assign o_ack       = ack_q;
  assign o_mux_en    = |ack_q;
  assign o_busy      = |ack_q;
  assign o_mux_cmd   = COMMAND_WIDTH'(ack_q[1]);
  assign o_mux_valid = i_req & ack_q;

endmodule
